// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetch stage.
//
// Issues one word-aligned request at a time to instruction memory.
// It registers the returned word for the decode stage and handshakes
// it out with instr_valid / instr_ready. Redirects (taken branches/jumps)
// can arrive in any state:
//   - FETCH with ack     : the returned word is dropped and the new target is requested.
//   - FETCH without ack  : the target is parked in `pending`; the FSM waits in DROP
//                          for the in-flight ack, then throws that data away.
//   - HOLD               : the buffered instruction is squashed.
//
// Ports
//   clk          in   clock, rising edge
//   R            in   asynchronous active-high reset
//   imem_req     out  memory request (FETCH or DROP)
//   imem_addr    out  fetch address (= pc), stable while imem_req=1
//   imem_ack     in   one-cycle data-valid pulse, may coincide with imem_req
//   imem_rdata   in   fetched instruction word
//   instr        out  registered instruction to decode
//   instr_pc     out  address of instr
//   instr_valid  out  instr holds an undelivered instruction
//   instr_ready  in   decode accepts instr this cycle
//   redirect     in   taken branch / jump
//   redirect_pc  in   redirect target (bits [1:0] ignored)
//   fetch_count  out  number of delivered instructions (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        R,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pending;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // State register
  always_ff @(posedge clk or posedge R) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (imem_ack && !redirect)      state_nxt = HOLD;
        else if (!imem_ack && redirect) state_nxt = DROP;
      end
      HOLD: begin
        if (redirect || instr_ready) state_nxt = FETCH;
      end
      DROP: begin
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    imem_req  = (state == FETCH) || (state == DROP);
    imem_addr = pc;
  end

  // pc, pending target and the delivery register
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      pc          <= RESET_PC;
      pending     <= 32'h0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fetch_count <= 16'h0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack && !redirect) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
          end else if (imem_ack && redirect) begin
            pc <= redirect_tgt;
          end else if (redirect) begin
            pending <= redirect_tgt;
          end
        end
        DROP: begin
          // A redirect in the ack cycle is newer than the parked one.
          if (imem_ack)      pc      <= redirect ? redirect_tgt : pending;
          else if (redirect) pending <= redirect_tgt;
        end
        HOLD: begin
          if (redirect || instr_ready) instr_valid <= 1'b0;
          if (redirect)                pc          <= redirect_tgt;
          if (instr_ready)             fetch_count <= fetch_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit. A behavioural memory with
// configurable latency (or a forced ack) feeds the main instance; a second
// instance with RESET_PC=0xFFFF_FFFC runs with zero-wait memory and an
// always-ready decode stage to exercise pc wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        R;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] fetch_count;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [31:0] ipc2;
  logic        valid2;
  logic [15:0] count2;

  logic        mem_en;
  logic        force_ack;
  int          lat;
  int          cnt;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] saved_instr;

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  assign imem_ack   = force_ack | (mem_en && imem_req && (cnt == lat));
  assign imem_rdata = mdata(imem_addr);
  assign rdata2     = mdata(addr2);

  // Wait-cycle counter for the latency memory model
  always @(posedge clk or posedge R) begin
    if (R)                                    cnt <= 0;
    else if (!imem_req || imem_ack || !mem_en) cnt <= 0;
    else                                      cnt <= cnt + 1;
  end

  fetch_unit dut (
    .clk(clk), .R(R), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .R(R), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(rdata2), .instr(instr2),
    .instr_pc(ipc2), .instr_valid(valid2), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0), .fetch_count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b0; mem_en = 1'b0; force_ack = 1'b0; lat = 0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #2 R = 1'b1;
    tick(); tick();
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %0h want 0", imem_req); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h want 0", instr); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0h want 0", instr_valid); end
    tests++; if (fetch_count !== 16'h0) begin fails++; $display("FAIL rst_count got %0d want 0", fetch_count); end
    // Stray ack while IDLE must not be captured
    R = 1'b0; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req got %0h want 1", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL first_addr got %h want 0", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL idle_ack_ignored got %0h want 0", instr_valid); end
  endtask

  task automatic test_stream();
    mem_en = 1'b1; lat = 0; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %0h want 1", k, instr_valid); end
      tests++; if (instr_pc !== 32'(4 * k)) begin fails++; $display("FAIL stream_pc[%0d] got %h want %h", k, instr_pc, 32'(4 * k)); end
      tests++; if (instr !== mdata(32'(4 * k))) begin fails++; $display("FAIL stream_instr[%0d] got %h want %h", k, instr, mdata(32'(4 * k))); end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stream_hold_req[%0d] got %0h want 0", k, imem_req); end
      tick();
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stream_clear[%0d] got %0h want 0", k, instr_valid); end
      tests++; if (imem_addr !== 32'(4 * k + 4)) begin fails++; $display("FAIL stream_addr[%0d] got %h want %h", k, imem_addr, 32'(4 * k + 4)); end
      tests++; if (fetch_count !== 16'(k + 1)) begin fails++; $display("FAIL stream_count[%0d] got %0d want %0d", k, fetch_count, k + 1); end
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    tick();
    saved_instr = instr;
    tests++; if (instr_pc !== 32'h10) begin fails++; $display("FAIL stall_pc got %h want 10", instr_pc); end
    tests++; if (saved_instr !== mdata(32'h10)) begin fails++; $display("FAIL stall_instr got %h want %h", saved_instr, mdata(32'h10)); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (instr_valid !== 1'b1 || instr !== saved_instr || instr_pc !== 32'h10) begin
        fails++; $display("FAIL stall_stable[%0d] got v=%0h i=%h pc=%h want v=1 i=%h pc=10", i, instr_valid, instr, instr_pc, saved_instr);
      end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req[%0d] got %0h want 0", i, imem_req); end
    end
    instr_ready = 1'b1;
    tick();
    mem_en = 1'b0;
    tests++; if (fetch_count !== 16'd5) begin fails++; $display("FAIL stall_count got %0d want 5", fetch_count); end
    tests++; if (imem_addr !== 32'h14 || imem_req !== 1'b1) begin fails++; $display("FAIL stall_next got req=%0h addr=%h want req=1 addr=14", imem_req, imem_addr); end
  endtask

  task automatic test_latency_redirect();
    lat = 3; mem_en = 1'b1; instr_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    tests++; if (imem_addr !== 32'h14 || imem_req !== 1'b1) begin fails++; $display("FAIL drop_hold_addr got req=%0h addr=%h want req=1 addr=14", imem_req, imem_addr); end
    tick();
    tests++; if (imem_addr !== 32'h14 || imem_ack !== 1'b1) begin fails++; $display("FAIL drop_ack_addr got ack=%0h addr=%h want ack=1 addr=14", imem_ack, imem_addr); end
    tick();
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL lat_redirect_addr got %h want 100", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL lat_discard got %0h want 0", instr_valid); end
    for (int i = 0; i < 8 && instr_valid !== 1'b1; i++) tick();
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL lat_timeout got %0h want 1", instr_valid); end
    tests++; if (instr_pc !== 32'h100 || instr !== mdata(32'h100)) begin fails++; $display("FAIL lat_deliver got pc=%h i=%h want pc=100 i=%h", instr_pc, instr, mdata(32'h100)); end
    tick();
    mem_en = 1'b0;
    tests++; if (fetch_count !== 16'd6 || imem_addr !== 32'h104) begin fails++; $display("FAIL lat_next got cnt=%0d addr=%h want cnt=6 addr=104", fetch_count, imem_addr); end
  endtask

  task automatic test_redirects();
    force_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h180;
    tick();
    force_ack = 1'b0;
    tests++; if (instr_valid !== 1'b0 || fetch_count !== 16'd6) begin fails++; $display("FAIL same_cycle_nodeliver got v=%0h cnt=%0d want v=0 cnt=6", instr_valid, fetch_count); end
    tests++; if (imem_addr !== 32'h180 || imem_req !== 1'b1) begin fails++; $display("FAIL same_cycle_addr got req=%0h addr=%h want req=1 addr=180", imem_req, imem_addr); end
    redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h302;
    tests++; if (imem_addr !== 32'h180) begin fails++; $display("FAIL drop1_addr got %h want 180", imem_addr); end
    tick();
    redirect = 1'b0; force_ack = 1'b1;
    tests++; if (imem_addr !== 32'h180) begin fails++; $display("FAIL drop2_addr got %h want 180", imem_addr); end
    tick();
    force_ack = 1'b0;
    tests++; if (imem_addr !== 32'h300 || instr_valid !== 1'b0) begin fails++; $display("FAIL drop_last_wins got addr=%h v=%0h want addr=300 v=0", imem_addr, instr_valid); end
  endtask

  task automatic test_hold_redirect();
    mem_en = 1'b1; lat = 0; instr_ready = 1'b0;
    tick();
    mem_en = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin fails++; $display("FAIL hold_a got v=%0h pc=%h want v=1 pc=300", instr_valid, instr_pc); end
    redirect = 1'b1; redirect_pc = 32'h400; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0; mem_en = 1'b1;
    tests++; if (instr_valid !== 1'b0 || fetch_count !== 16'd7 || imem_addr !== 32'h400) begin
      fails++; $display("FAIL hold_redir_ready got v=%0h cnt=%0d addr=%h want v=0 cnt=7 addr=400", instr_valid, fetch_count, imem_addr);
    end
    tick();
    mem_en = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400) begin fails++; $display("FAIL hold_b got v=%0h pc=%h want v=1 pc=400", instr_valid, instr_pc); end
    redirect = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect = 1'b0;
    tests++; if (instr_valid !== 1'b0 || fetch_count !== 16'd7 || imem_addr !== 32'h500) begin
      fails++; $display("FAIL hold_redir_noready got v=%0h cnt=%0d addr=%h want v=0 cnt=7 addr=500", instr_valid, fetch_count, imem_addr);
    end
  endtask

  task automatic test_reset_in_drop();
    redirect = 1'b1; redirect_pc = 32'h600;
    tick();
    redirect = 1'b0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h500) begin fails++; $display("FAIL pre_rst_drop got req=%0h addr=%h want req=1 addr=500", imem_req, imem_addr); end
    R = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL async_rst_req got req=%0h addr=%h want req=0 addr=0", imem_req, imem_addr); end
    tests++; if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_valid !== 1'b0 || fetch_count !== 16'h0) begin
      fails++; $display("FAIL async_rst_regs got i=%h pc=%h v=%0h cnt=%0d want all 0", instr, instr_pc, instr_valid, fetch_count);
    end
    force_ack = 1'b1;
    tick();
    R = 1'b0;
    tick();
    force_ack = 1'b0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL post_rst_fetch got req=%0h addr=%h v=%0h want req=1 addr=0 v=0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_pc_wrap();
    tests++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_first_addr got req=%0h addr=%h want req=1 addr=fffffffc", req2, addr2); end
    tick();
    tests++; if (valid2 !== 1'b1 || ipc2 !== 32'hFFFF_FFFC || instr2 !== mdata(32'hFFFF_FFFC)) begin
      fails++; $display("FAIL wrap_first_instr got v=%0h pc=%h i=%h want v=1 pc=fffffffc i=%h", valid2, ipc2, instr2, mdata(32'hFFFF_FFFC));
    end
    tick();
    tests++; if (req2 !== 1'b1 || addr2 !== 32'h0 || count2 !== 16'd1) begin fails++; $display("FAIL wrap_second_addr got req=%0h addr=%h cnt=%0d want req=1 addr=0 cnt=1", req2, addr2, count2); end
    tick();
    tests++; if (valid2 !== 1'b1 || ipc2 !== 32'h0) begin fails++; $display("FAIL wrap_second_instr got v=%0h pc=%h want v=1 pc=0", valid2, ipc2); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency_redirect();
    test_redirects();
    test_hold_redirect();
    test_reset_in_drop();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
